piso_serializer_n: RTL and testbench

PISO_SERIALIZER_N -- requirements
Module: piso_serializer_n

---
 rtl/piso_serializer_n.sv | 80 ++++++++
 tb/tb_piso_serializer_n.sv | 123 ++++++++++++
 2 files changed

// File: rtl/piso_serializer_n.sv
// piso_serializer_n: multi-lane parallel-to-serial framer with idle fill (optional parity via SER_PARITY_EN)
module piso_serializer_n #(
  parameter int DATA_W    = 8,
  parameter int LANES     = 1,
  parameter int IDLE_WORD = 8'hBC,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [LANES-1:0]        ser_out,
  output logic                    frame_start,
  output logic                    frame_is_data,
  output logic [15:0]             idle_count
);
`ifdef SER_PARITY_EN
  localparam int FL = DATA_W + 1;
`else
  localparam int FL = DATA_W;
`endif
  localparam int CW = $clog2(FL);
  localparam logic [DATA_W-1:0] IDLE_W = DATA_W'(IDLE_WORD);
  typedef enum logic {RESET_Z, STREAM} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] wd [LANES];
  logic [DATA_W-1:0] od [LANES];
  logic [FL-1:0] fr [LANES];
  logic [FL-1:0] sh [LANES];
  // state register: RESET_Z holds for the single cycle after reset
  always_ff @(posedge clk)
    state <= reset ? RESET_Z : state_nx;
  // next state and handshake; a frame boundary is the only time a word can be taken
  always_comb begin
    state_nx = STREAM;
    in_ready = !reset && (state == RESET_Z || cnt == '0);
  end
  // build each lane's frame in transmit order, first bit at the top
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      wd[l] = in_valid ? in_data[l*DATA_W +: DATA_W] : IDLE_W;
      for (int b = 0; b < DATA_W; b++)
        od[l][b] = (MSB_FIRST != 0) ? wd[l][b] : wd[l][DATA_W-1-b];
`ifdef SER_PARITY_EN
      fr[l] = {od[l], ^wd[l]};
`else
      fr[l] = od[l];
`endif
    end
  end
  // load a full frame at each boundary, shift out one bit per cycle otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      ser_out       <= '0;
      frame_start   <= 1'b0;
      frame_is_data <= 1'b0;
      idle_count    <= '0;
      for (int l = 0; l < LANES; l++) sh[l] <= '0;
    end else if (in_ready) begin
      cnt           <= CW'(FL - 1);
      frame_start   <= 1'b1;
      frame_is_data <= in_valid;
      if (!in_valid && idle_count != 16'hFFFF) idle_count <= idle_count + 16'd1;
      for (int l = 0; l < LANES; l++) begin
        ser_out[l] <= fr[l][FL-1];
        sh[l]      <= fr[l] << 1;
      end
    end else begin
      cnt         <= cnt - 1'b1;
      frame_start <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        ser_out[l] <= sh[l][FL-1];
        sh[l]      <= sh[l] << 1;
      end
    end
  end
endmodule

// File: tb/tb_piso_serializer_n.sv
// tb_piso_serializer_n: directed checks of framing, idle fill, lanes, bit order and reset
module tb_piso_serializer_n;
`ifdef SER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  logic [7:0]  a_data, c_data;
  logic [15:0] b_data;
  logic a_valid, b_valid, c_valid, a_ready, b_ready, c_ready;
  logic [0:0] a_ser, c_ser;
  logic [1:0] b_ser;
  logic a_fs, b_fs, c_fs, a_fd, b_fd, c_fd;
  logic [15:0] a_ic, b_ic, c_ic;
  int passed = 0;
  int total = 0;
  piso_serializer_n dut_a (.clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .ser_out(a_ser), .frame_start(a_fs), .frame_is_data(a_fd), .idle_count(a_ic));
  piso_serializer_n #(.LANES(2)) dut_b (.clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .ser_out(b_ser), .frame_start(b_fs), .frame_is_data(b_fd), .idle_count(b_ic));
  piso_serializer_n #(.MSB_FIRST(0)) dut_c (.clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .ser_out(c_ser), .frame_start(c_fs), .frame_is_data(c_fd), .idle_count(c_ic));
  function automatic logic eb(input logic [7:0] w, input int k, input bit msb);
    if (k == 8) return ^w;
    return msb ? w[7-k] : w[k];
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask
  task automatic ca(input logic [7:0] w, input int k, input logic fd, input logic [15:0] ic);
    chk("a_ser", a_ser, eb(w, k, 1));
    chk("a_fs", a_fs, k == 0);
    chk("a_fd", a_fd, fd);
    chk("a_ready", a_ready, k == FL - 1);
    chk("a_ic", a_ic, ic);
  endtask
  task automatic chk_reset;
    chk("rst_ser", a_ser, 0);
    chk("rst_fs", a_fs, 0);
    chk("rst_fd", a_fd, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_ic", a_ic, 0);
    chk("rst_b_ready", b_ready, 0);
  endtask
  logic [7:0] wl [3];
  initial begin
    wl = '{8'h01, 8'h02, 8'h03};
    a_data = 0; b_data = 0; c_data = 0;
    a_valid = 0; b_valid = 0; c_valid = 0;
    tick;
    tick;
    chk_reset;
    reset = 0;
    #1;
    chk("rz_ready", a_ready, 1);
    chk("rz_ser", a_ser, 0);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < FL; k++) begin
        tick;
        ca(8'hBC, k, 0, 16'(f + 1));
      end
    a_valid = 1;
    a_data = wl[0];
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < FL; k++) begin
        tick;
        ca(wl[i], k, 1, 2);
        if (k == FL - 1) a_data = (i < 2) ? wl[i+1] : 8'hFF;
      end
    for (int k = 0; k < 5; k++) begin
      tick;
      ca(8'hFF, k, 1, 2);
    end
    a_valid = 0;
    reset = 1;
    tick;
    chk_reset;
    reset = 0;
    #1;
    chk("rz2_ready", a_ready, 1);
    chk("rz2_ser", a_ser, 0);
    for (int k = 0; k < FL; k++) begin
      tick;
      ca(8'hBC, k, 0, 1);
      if (k == FL - 1) begin
        chk("b_ready", b_ready, 1);
        chk("c_ready", c_ready, 1);
        b_valid = 1; b_data = 16'hA55A;
        c_valid = 1; c_data = 8'h80;
      end
    end
    for (int k = 0; k < FL; k++) begin
      tick;
      if (k == 0) begin b_valid = 0; c_valid = 0; end
      if (k == 2) begin b_valid = 1; b_data = 16'hFFFF; end
      if (k == FL - 2) b_valid = 0;
      chk("b_ser", b_ser, {eb(8'hA5, k, 1), eb(8'h5A, k, 1)});
      chk("b_fs", b_fs, k == 0);
      chk("b_fd", b_fd, 1);
      chk("b_ic", b_ic, 1);
      chk("c_ser", c_ser, eb(8'h80, k, 0));
      chk("c_fd", c_fd, 1);
    end
    tick;
    chk("b_idle_fd", b_fd, 0);
    chk("b_idle_fs", b_fs, 1);
    chk("b_idle_ser", b_ser, 2'b11);
    chk("b_idle_ic", b_ic, 2);
    chk("c_idle_ic", c_ic, 2);
    chk("c_idle_ser", c_ser, eb(8'hBC, 0, 0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
